// File: rtl/axis_yuv422_unpack_if.sv
// AXI4-Stream bundle shared by the 36-bit component side and the 16-bit packed
// YUV422 side of the unpacker.
interface axis_yuv422_unpack_if #(
    parameter int DW = 16
) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tuser;
    logic          tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_yuv422_unpack.sv
// Repacks 36-bit chroma/luma component beats into 16-bit YUV422 words behind a
// registered output stage with a one-entry skid, and tracks per-line pixel counts.
module axis_yuv422_unpack #(
    parameter string C_COLOR_FORMAT     = "YUV422",
    parameter int    C_INPUT_DATAWIDTH  = 36,
    parameter int    C_OUTPUT_DATAWIDTH = 16,
    parameter int    C_ROUND            = 1,
    parameter int    C_MAX_PIXELS       = 4096,
    localparam int   CW                 = $clog2(C_MAX_PIXELS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_yuv422_unpack_if.slave   s_axis,
    axis_yuv422_unpack_if.master  m_axis,
    output logic [CW-1:0]         line_len,
    output logic                  err_odd_line,
    output logic                  err_sof_midline,
    input  logic                  err_clr
);

    // An unsupported configuration never raises ready, so nothing is ever accepted.
    localparam bit ACTIVE = (C_COLOR_FORMAT == "YUV422") &&
                            (C_INPUT_DATAWIDTH == 36) && (C_OUTPUT_DATAWIDTH == 16);
    localparam logic [CW-1:0] MAX_CNT = CW'(C_MAX_PIXELS);

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_t;

    occ_t          occ_q, occ_d;
    logic          ready_q, ready_d;
    logic [15:0]   outData_q, outData_d;
    logic          outUser_q, outUser_d;
    logic          outLast_q, outLast_d;
    logic [15:0]   skidData_q, skidData_d;
    logic          skidUser_q, skidUser_d;
    logic          skidLast_q, skidLast_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] lineLen_q, lineLen_d;
    logic          errOdd_q, errOdd_d;
    logic          errSof_q, errSof_d;

    logic          inAcc;
    logic          outAcc;
    logic [15:0]   convData;
    logic [CW-1:0] countNext;
    logic          oddEvent;
    logic          sofEvent;
    logic          unused_lowBits;

    function automatic logic [7:0] conv12(input logic [11:0] c);
        logic [7:0] r;
        if (C_ROUND == 0) begin
            r = c[11:4];
        end else if (c >= 12'hFF8) begin
            r = 8'hFF;
        end else begin
            r = 8'((c + 12'd8) >> 4);
        end
        return r;
    endfunction

    assign unused_lowBits = ^s_axis.tdata[11:0];

    assign inAcc    = s_axis.tvalid && ready_q;
    assign outAcc   = (occ_q != OCC_EMPTY) && m_axis.tready;
    assign convData = {conv12(s_axis.tdata[35:24]), conv12(s_axis.tdata[23:12])};

    always_comb begin
        occ_d      = occ_q;
        outData_d  = outData_q;
        outUser_d  = outUser_q;
        outLast_d  = outLast_q;
        skidData_d = skidData_q;
        skidUser_d = skidUser_q;
        skidLast_d = skidLast_q;

        case (occ_q)
            OCC_EMPTY: begin
                if (inAcc) begin
                    outData_d = convData;
                    outUser_d = s_axis.tuser;
                    outLast_d = s_axis.tlast;
                    occ_d     = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (outAcc) begin
                    if (inAcc) begin
                        outData_d = convData;
                        outUser_d = s_axis.tuser;
                        outLast_d = s_axis.tlast;
                    end else begin
                        occ_d = OCC_EMPTY;
                    end
                end else if (inAcc) begin
                    skidData_d = convData;
                    skidUser_d = s_axis.tuser;
                    skidLast_d = s_axis.tlast;
                    occ_d      = OCC_FULL;
                end
            end
            OCC_FULL: begin
                // Ready is low here, so the only legal move is skid -> output.
                if (outAcc) begin
                    outData_d = skidData_q;
                    outUser_d = skidUser_q;
                    outLast_d = skidLast_q;
                    occ_d     = OCC_ONE;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase

        ready_d = ACTIVE && (occ_d != OCC_FULL);
    end

    always_comb begin
        count_d   = count_q;
        lineLen_d = lineLen_q;
        countNext = '0;
        oddEvent  = 1'b0;
        sofEvent  = 1'b0;

        if (inAcc) begin
            sofEvent = s_axis.tuser && (count_q != '0);
            if (s_axis.tuser) begin
                countNext = CW'(1);
            end else if (count_q >= MAX_CNT) begin
                countNext = MAX_CNT;
            end else begin
                countNext = count_q + CW'(1);
            end

            if (s_axis.tlast) begin
                lineLen_d = countNext;
                count_d   = '0;
                oddEvent  = countNext[0];
            end else begin
                count_d = countNext;
            end
        end

        // A fresh error event outranks a clear pulse in the same cycle.
        errOdd_d = (errOdd_q && !err_clr) || oddEvent;
        errSof_d = (errSof_q && !err_clr) || sofEvent;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= OCC_EMPTY;
            ready_q    <= 1'b0;
            outData_q  <= '0;
            outUser_q  <= 1'b0;
            outLast_q  <= 1'b0;
            skidData_q <= '0;
            skidUser_q <= 1'b0;
            skidLast_q <= 1'b0;
            count_q    <= '0;
            lineLen_q  <= '0;
            errOdd_q   <= 1'b0;
            errSof_q   <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            ready_q    <= ready_d;
            outData_q  <= outData_d;
            outUser_q  <= outUser_d;
            outLast_q  <= outLast_d;
            skidData_q <= skidData_d;
            skidUser_q <= skidUser_d;
            skidLast_q <= skidLast_d;
            count_q    <= count_d;
            lineLen_q  <= lineLen_d;
            errOdd_q   <= errOdd_d;
            errSof_q   <= errSof_d;
        end
    end

    assign s_axis.tready   = ready_q;
    assign m_axis.tvalid   = (occ_q != OCC_EMPTY);
    assign m_axis.tdata    = outData_q;
    assign m_axis.tuser    = outUser_q;
    assign m_axis.tlast    = outLast_q;
    assign line_len        = lineLen_q;
    assign err_odd_line    = errOdd_q;
    assign err_sof_midline = errSof_q;

endmodule

// File: tb/tb_axis_yuv422_unpack.sv
// Bench for axis_yuv422_unpack: a rounding instance and a truncating, short-line
// instance share stimulus and are compared each cycle against a queue-based model.
module tb_axis_yuv422_unpack;

    localparam int MAXP_R = 4096;
    localparam int MAXP_T = 5;

    logic        clk;
    logic        rst;
    logic        sValid;
    logic [35:0] sData;
    logic        sUser;
    logic        sLast;
    logic        mReady;
    logic        errClr;

    logic [12:0] lineLenR;
    logic [2:0]  lineLenT;
    logic        errOddR, errSofR, errOddT, errSofT;

    int total = 0;
    int bad   = 0;

    // Model state: beats held inside the DUT, registered ready, and line tracking.
    logic [37:0] pipeQ[$];
    bit          readyExp = 0;
    bit          lastAcc  = 0;
    bit          checksOn = 0;
    int          cntM[2];
    int          lenM[2];
    bit          errOddM[2];
    bit          errSofM[2];

    axis_yuv422_unpack_if #(.DW(36)) sIfR ();
    axis_yuv422_unpack_if #(.DW(16)) mIfR ();
    axis_yuv422_unpack_if #(.DW(36)) sIfT ();
    axis_yuv422_unpack_if #(.DW(16)) mIfT ();

    assign sIfR.tdata  = sData;
    assign sIfR.tvalid = sValid;
    assign sIfR.tuser  = sUser;
    assign sIfR.tlast  = sLast;
    assign mIfR.tready = mReady;
    assign sIfT.tdata  = sData;
    assign sIfT.tvalid = sValid;
    assign sIfT.tuser  = sUser;
    assign sIfT.tlast  = sLast;
    assign mIfT.tready = mReady;

    axis_yuv422_unpack #(.C_ROUND(1), .C_MAX_PIXELS(MAXP_R)) dutR (
        .clk             (clk),
        .rst             (rst),
        .s_axis          (sIfR),
        .m_axis          (mIfR),
        .line_len        (lineLenR),
        .err_odd_line    (errOddR),
        .err_sof_midline (errSofR),
        .err_clr         (errClr)
    );

    axis_yuv422_unpack #(.C_ROUND(0), .C_MAX_PIXELS(MAXP_T)) dutT (
        .clk             (clk),
        .rst             (rst),
        .s_axis          (sIfT),
        .m_axis          (mIfT),
        .line_len        (lineLenT),
        .err_odd_line    (errOddT),
        .err_sof_midline (errSofT),
        .err_clr         (errClr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] refConv(logic [11:0] c, bit rnd);
        int v;
        v = int'(c);
        if (!rnd) return 8'(v / 16);
        if (v >= 4088) return 8'd255;
        return 8'((v + 8) / 16);
    endfunction

    task automatic checkValue(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkInst(string nm, bit rnd, logic rdy, logic vld, logic [15:0] d,
                             logic u, logic l, logic [31:0] len, logic eo, logic es, int i);
        logic [37:0] h;
        checkValue({nm, ".tready"}, 32'(rdy), 32'(readyExp));
        checkValue({nm, ".tvalid"}, 32'(vld), 32'(pipeQ.size() > 0));
        if (pipeQ.size() > 0) begin
            h = pipeQ[0];
            checkValue({nm, ".tdata"}, 32'(d), 32'({refConv(h[35:24], rnd), refConv(h[23:12], rnd)}));
            checkValue({nm, ".tuser"}, 32'(u), 32'(h[37]));
            checkValue({nm, ".tlast"}, 32'(l), 32'(h[36]));
        end
        checkValue({nm, ".line_len"}, len, 32'(lenM[i]));
        checkValue({nm, ".err_odd"}, 32'(eo), 32'(errOddM[i]));
        checkValue({nm, ".err_sof"}, 32'(es), 32'(errSofM[i]));
    endtask

    task automatic checkOutput();
        checkInst("rnd", 1'b1, sIfR.tready, mIfR.tvalid, mIfR.tdata, mIfR.tuser, mIfR.tlast,
                  32'(lineLenR), errOddR, errSofR, 0);
        checkInst("trn", 1'b0, sIfT.tready, mIfT.tvalid, mIfT.tdata, mIfT.tuser, mIfT.tlast,
                  32'(lineLenT), errOddT, errSofT, 1);
    endtask

    task automatic updateModel();
        bit acc, pop, oddEv, sofEv;
        int nxt, maxp;
        lastAcc = 1'b0;
        if (rst) begin
            pipeQ.delete();
            readyExp = 1'b0;
            for (int i = 0; i < 2; i++) begin
                cntM[i] = 0; lenM[i] = 0; errOddM[i] = 1'b0; errSofM[i] = 1'b0;
            end
            return;
        end
        acc = sValid && readyExp;
        pop = (pipeQ.size() > 0) && mReady;
        if (pop) void'(pipeQ.pop_front());
        if (acc) pipeQ.push_back({sUser, sLast, sData});
        readyExp = (pipeQ.size() < 2);
        lastAcc  = acc;
        for (int i = 0; i < 2; i++) begin
            maxp  = (i == 0) ? MAXP_R : MAXP_T;
            oddEv = 1'b0;
            sofEv = 1'b0;
            if (acc) begin
                if (sUser) begin
                    sofEv = (cntM[i] != 0);
                    nxt   = 1;
                end else begin
                    nxt = (cntM[i] + 1 > maxp) ? maxp : cntM[i] + 1;
                end
                if (sLast) begin
                    lenM[i] = nxt;
                    cntM[i] = 0;
                    oddEv   = (nxt % 2 == 1);
                end else begin
                    cntM[i] = nxt;
                end
            end
            errOddM[i] = (errOddM[i] && !errClr) || oddEv;
            errSofM[i] = (errSofM[i] && !errClr) || sofEv;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (checksOn) checkOutput();
        @(posedge clk);
        updateModel();
        #1;
    endtask

    task automatic applyStimulus(bit v, logic [35:0] d, bit u, bit l);
        sValid = v;
        sData  = d;
        sUser  = u;
        sLast  = l;
        cycle();
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 36'h0, 1'b0, 1'b0);
    endtask

    task automatic sendBeat(logic [35:0] d, bit u, bit l);
        int n;
        n = 0;
        applyStimulus(1'b1, d, u, l);
        while (!lastAcc && n < 40) begin
            applyStimulus(1'b1, d, u, l);
            n++;
        end
        if (!lastAcc) begin
            total++;
            bad++;
            $display("[TB] FAIL sendTimeout observed=no_accept expected=accept data=%0h", d);
        end
    endtask

    task automatic sendLine(int n, bit sof);
        for (int k = 0; k < n; k++)
            sendBeat({4'($urandom()), 32'($urandom())}, sof && (k == 0), k == n - 1);
    endtask

    initial begin
        bit          pend;
        logic [35:0] pd;
        bit          pu, pl;

        rst = 1'b1; sValid = 1'b0; sData = '0; sUser = 1'b0; sLast = 1'b0;
        mReady = 1'b1; errClr = 1'b0;

        $display("[TB] reset");
        cycle();
        checksOn = 1'b1;
        cycle();
        rst = 1'b0;
        idle(3);

        $display("[TB] basic 4-beat line");
        sendBeat(36'hAB0_CD0_000, 1'b1, 1'b0);
        sendBeat(36'h123_456_789, 1'b0, 1'b0);
        sendBeat(36'hFED_010_0FF, 1'b0, 1'b0);
        sendBeat(36'h800_7FF_ABC, 1'b0, 1'b1);
        idle(2);

        $display("[TB] rounding and saturation");
        sendBeat(36'h7F8_7F7_000, 1'b0, 1'b0);
        sendBeat(36'hFF8_FFF_000, 1'b0, 1'b0);
        sendBeat(36'h000_FF7_000, 1'b0, 1'b0);
        sendBeat(36'h008_007_000, 1'b0, 1'b1);
        idle(2);

        $display("[TB] backpressure");
        mReady = 1'b0;
        sendBeat(36'h111_222_000, 1'b1, 1'b0);
        sendBeat(36'h333_444_000, 1'b0, 1'b0);
        applyStimulus(1'b1, 36'h555_666_000, 1'b0, 1'b0);
        applyStimulus(1'b1, 36'h555_666_000, 1'b0, 1'b0);
        mReady = 1'b1;
        sendBeat(36'h555_666_000, 1'b0, 1'b0);
        sendBeat(36'h777_888_000, 1'b0, 1'b1);
        idle(3);

        $display("[TB] odd line and error clear");
        sendLine(3, 1'b1);
        idle(2);
        errClr = 1'b1;
        idle(1);
        errClr = 1'b0;
        idle(1);
        sendLine(3, 1'b0);
        idle(1);
        sendBeat(36'h123_123_000, 1'b0, 1'b0);
        sendBeat(36'h123_123_000, 1'b0, 1'b0);
        errClr = 1'b1;
        sendBeat(36'h123_123_000, 1'b0, 1'b1);
        errClr = 1'b0;
        idle(2);

        $display("[TB] SOF mid-line");
        sendLine(4, 1'b1);
        idle(1);
        for (int k = 0; k < 4; k++) sendBeat(36'h456_789_000, 1'b0, 1'b0);
        sendBeat(36'hABC_DEF_000, 1'b1, 1'b0);
        sendBeat(36'h456_789_000, 1'b0, 1'b0);
        sendBeat(36'h456_789_000, 1'b0, 1'b1);
        idle(2);
        errClr = 1'b1;
        idle(1);
        errClr = 1'b0;

        $display("[TB] long line, counter saturation");
        sendLine(8, 1'b1);
        idle(2);

        $display("[TB] reset mid-transfer");
        mReady = 1'b0;
        sendBeat(36'h9AB_CDE_000, 1'b1, 1'b0);
        sendBeat(36'h876_543_000, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 36'h111_111_000, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 36'h0, 1'b0, 1'b0);
        mReady = 1'b1;
        idle(1);
        sendLine(2, 1'b0);
        idle(2);

        $display("[TB] randomized traffic");
        pend = 1'b0; pd = '0; pu = 1'b0; pl = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (!pend && ($urandom_range(0, 3) != 0)) begin
                pend = 1'b1;
                pd   = {4'($urandom()), 32'($urandom())};
                pu   = ($urandom_range(0, 9) == 0);
                pl   = ($urandom_range(0, 5) == 0);
            end
            mReady = ($urandom_range(0, 3) != 0);
            errClr = ($urandom_range(0, 15) == 0);
            applyStimulus(pend, pd, pu, pl);
            if (lastAcc) pend = 1'b0;
        end
        errClr = 1'b0;
        mReady = 1'b1;
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
